// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan: latches packed BCD + carry and scans it onto a 4-digit multiplexed 7-segment display.
// Define BCD_SEG_LZB_EN to blank leading zero digits (digit 0 is always shown).
module bcd_seg_scan #(
  parameter int CLK_DIV        = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] bcd_in,
  input  logic        ovf_in,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        err
);
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0] AN_OFF = AN_ACTIVE_LOW ? 4'hF : 4'h0;
  logic [15:0]   disp_q, disp_d;
  logic          ovf_q, ovf_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [1:0]    idx_q, idx_d;
  logic          err_q, err_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          dp_q, dp_d;
  logic          tick, blank;
  logic [3:0]    nib;
  function automatic logic [6:0] dec(input logic [3:0] v);
    case (v)
      4'd0: dec = 7'h3F;
      4'd1: dec = 7'h06;
      4'd2: dec = 7'h5B;
      4'd3: dec = 7'h4F;
      4'd4: dec = 7'h66;
      4'd5: dec = 7'h6D;
      4'd6: dec = 7'h7D;
      4'd7: dec = 7'h07;
      4'd8: dec = 7'h7F;
      4'd9: dec = 7'h6F;
      default: dec = 7'h40;
    endcase
  endfunction
`ifdef BCD_SEG_LZB_EN
  logic [3:0] lz;
  // A digit is a leading zero only if it and every digit above it are zero
  assign lz = {disp_q[15:12] == 4'd0, disp_q[15:8] == 8'd0, disp_q[15:4] == 12'd0, 1'b0};
  assign blank = lz[idx_q];
`else
  assign blank = 1'b0;
`endif
  always_comb begin
    tick   = pre_q == PMAX;
    pre_d  = tick ? '0 : pre_q + PW'(1);
    idx_d  = tick ? idx_q + 2'd1 : idx_q;
    disp_d = load ? bcd_in : disp_q;
    ovf_d  = load ? ovf_in : ovf_q;
    err_d  = (disp_q[3:0] > 4'd9) | (disp_q[7:4] > 4'd9) | (disp_q[11:8] > 4'd9) | (disp_q[15:12] > 4'd9);
    nib    = disp_q[{idx_q, 2'b00} +: 4];
    seg_d  = (blank ? 7'h00 : dec(nib)) ^ {7{SEG_ACTIVE_LOW}};
    an_d   = (4'b0001 << idx_q) ^ {4{AN_ACTIVE_LOW}};
    dp_d   = ((idx_q == 2'd3) & ovf_q) ^ SEG_ACTIVE_LOW;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp_q <= '0;
      ovf_q  <= 1'b0;
      pre_q  <= '0;
      idx_q  <= '0;
      err_q  <= 1'b0;
      seg_q  <= SEG_OFF;
      an_q   <= AN_OFF;
      dp_q   <= SEG_ACTIVE_LOW;
    end else begin
      disp_q <= disp_d;
      ovf_q  <= ovf_d;
      pre_q  <= pre_d;
      idx_q  <= idx_d;
      err_q  <= err_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
      dp_q   <= dp_d;
    end
  end
  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;
  assign err = err_q;
endmodule

// File: tb/tb_bcd_seg_scan.sv
// tb_bcd_seg_scan: directed checks of bcd_seg_scan with CLK_DIV=4, active-low segments and anodes.
module tb_bcd_seg_scan;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] bcd_in = '0;
  logic        ovf_in = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        err;
  int checks = 0;
  int errors = 0;
  int n = 0;
  logic [6:0] es [4];
  logic       eo = 1'b0;
  logic       eerr = 1'b0;
  bcd_seg_scan #(.CLK_DIV(4), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .bcd_in(bcd_in), .ovf_in(ovf_in),
    .seg(seg), .dp(dp), .an(an), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s n=%0d got=%h exp=%h", tag, n, got, exp);
    end
  endtask
  task automatic chk_off(input string tag);
    chk({tag, "_an"}, {4'h0, an}, 8'h0F);
    chk({tag, "_seg"}, {1'b0, seg}, 8'h7F);
    chk({tag, "_dp"}, {7'h0, dp}, 8'h01);
    chk({tag, "_err"}, {7'h0, err}, 8'h00);
  endtask
  // Edge n after reset release shows digit ((n-1)/4)%4: each slot is 4 edges
  task automatic step_chk();
    int d;
    logic [3:0] ea;
    @(posedge clk);
    n++;
    #1;
    d = ((n - 1) / 4) % 4;
    ea = 4'hF ^ (4'b0001 << d);
    chk("an", {4'h0, an}, {4'h0, ea});
    chk("seg", {1'b0, seg}, {1'b0, es[d]});
    chk("dp", {7'h0, dp}, {7'h0, !(d == 3 && eo)});
    chk("err", {7'h0, err}, {7'h0, eerr});
  endtask
  task automatic set_es(input logic [6:0] s0, s1, s2, s3);
    es[0] = s0; es[1] = s1; es[2] = s2; es[3] = s3;
  endtask
  initial begin
    set_es(7'h40, 7'h40, 7'h40, 7'h40);
    repeat (3) @(posedge clk);
    #1;
    chk_off("reset");
    rst_n = 1'b1;
    step_chk();
    bcd_in = 16'h1234; ovf_in = 1'b1; load = 1'b1;
    step_chk();
    load = 1'b0;
    set_es(7'h19, 7'h30, 7'h24, 7'h79); eo = 1'b1;
    repeat (18) step_chk();
    bcd_in = 16'h9A05; ovf_in = 1'b0; load = 1'b1;
    step_chk();
    load = 1'b0;
    set_es(7'h12, 7'h40, 7'h3F, 7'h10); eo = 1'b0; eerr = 1'b1;
    repeat (16) step_chk();
    bcd_in = 16'h0000; load = 1'b1;
    step_chk();
    load = 1'b0;
    set_es(7'h40, 7'h40, 7'h40, 7'h40); eerr = 1'b0;
    repeat (5) step_chk();
    bcd_in = 16'h0007; load = 1'b1;
    step_chk();
    load = 1'b0;
    set_es(7'h78, 7'h40, 7'h40, 7'h40);
    repeat (16) step_chk();
    repeat (13) step_chk();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_off("midrst");
    rst_n = 1'b1; n = 0;
    set_es(7'h40, 7'h40, 7'h40, 7'h40);
    repeat (8) step_chk();
    bcd_in = 16'h0040; load = 1'b1;
    step_chk();
    load = 1'b0;
`ifdef BCD_SEG_LZB_EN
    set_es(7'h40, 7'h19, 7'h7F, 7'h7F);
`else
    set_es(7'h40, 7'h19, 7'h40, 7'h40);
`endif
    repeat (16) step_chk();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
